// File: rtl/vend_controller.sv
// Vending-machine controller: collects coin credit, requests a vend at PRICE,
// then pays change back one CHANGE_UNIT per hopper handshake.
module vend_controller #(
    parameter int CREDIT_W     = 8,
    parameter int PRICE        = 35,
    parameter int COIN_V0      = 5,
    parameter int COIN_V1      = 10,
    parameter int COIN_V2      = 25,
    parameter int COIN_V3      = 50,
    parameter int CHANGE_UNIT  = 5,
    parameter int VEND_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    input  logic                vend_ready,
    input  logic                change_ready,
    output logic                vend_valid,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                vend_fault,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam int                CNT_W        = $clog2(VEND_TIMEOUT + 1);
    localparam logic [CREDIT_W:0]   PRICE_X      = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C       = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(VEND_TIMEOUT - 1);

    if ((COIN_V0 % CHANGE_UNIT) != 0 || (COIN_V1 % CHANGE_UNIT) != 0 ||
        (COIN_V2 % CHANGE_UNIT) != 0 || (COIN_V3 % CHANGE_UNIT) != 0 ||
        (PRICE % CHANGE_UNIT) != 0) begin : g_unit_check
        $error("vend_controller: coin values and PRICE must be multiples of CHANGE_UNIT");
    end
    if (PRICE < 1 || PRICE > (2**CREDIT_W - 1) || VEND_TIMEOUT < 1) begin : g_range_check
        $error("vend_controller: PRICE or VEND_TIMEOUT out of range");
    end

    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return (CREDIT_W + 1)'(COIN_V0);
            2'd1:    return (CREDIT_W + 1)'(COIN_V1);
            2'd2:    return (CREDIT_W + 1)'(COIN_V2);
            default: return (CREDIT_W + 1)'(COIN_V3);
        endcase
    endfunction

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                reject_nx, fault_nx;
    logic [CREDIT_W:0]   sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            cnt         <= '0;
            coin_reject <= 1'b0;
            vend_fault  <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            cnt         <= cnt_nx;
            coin_reject <= reject_nx;
            vend_fault  <= fault_nx;
        end
    end

    // Sum is one bit wider than credit so its MSB flags an overflowing coin.
    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        cnt_nx    = cnt;
        reject_nx = 1'b0;
        fault_nx  = 1'b0;
        sum       = {1'b0, credit} + coin_value(coin_sel);
        case (state)
            IDLE, COLLECT: begin
                if (cancel && state == COLLECT) begin
                    state_nx  = CHANGE;
                    reject_nx = coin_valid;
                end else if (coin_valid) begin
                    if (sum[CREDIT_W]) begin
                        reject_nx = 1'b1;
                    end else begin
                        credit_nx = sum[CREDIT_W-1:0];
                        if (sum >= PRICE_X) begin
                            state_nx = VEND;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = COLLECT;
                        end
                    end
                end
            end
            VEND: begin
                reject_nx = coin_valid;
                if (vend_ready) begin
                    credit_nx = credit - PRICE_C;
                    state_nx  = (credit == PRICE_C) ? IDLE : CHANGE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx = CHANGE;
                    fault_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            CHANGE: begin
                reject_nx = coin_valid;
                if (change_ready) begin
                    credit_nx = credit - UNIT_C;
                    if (credit == UNIT_C) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        vend_valid   = (state == VEND);
        change_valid = (state == CHANGE);
        busy         = (state == VEND) || (state == CHANGE);
    end

    // Change is paid in whole units, so credit must always stay a multiple of one.
    a_credit_unit: assert property (@(posedge clk) disable iff (!rst_n)
        (credit % UNIT_C) == {CREDIT_W{1'b0}});

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: one instance at PRICE=35, one at PRICE=255,
// with handshake/pulse events scored against an expected-event queue.
module tb_vend_controller;

    localparam int EV_REJ   = 1;
    localparam int EV_FAULT = 2;
    localparam int EV_VEND  = 3;
    localparam int EV_CHG   = 4;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_b;
    logic       coin_valid, cancel, vend_ready, change_ready;
    logic [1:0] coin_sel;

    logic       vend_valid_a, change_valid_a, coin_reject_a, vend_fault_a, busy_a;
    logic [7:0] credit_a;
    logic       vend_valid_b, change_valid_b, coin_reject_b, vend_fault_b, busy_b;
    logic [7:0] credit_b;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    vend_controller #(.PRICE(35)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .cancel(cancel), .vend_ready(vend_ready), .change_ready(change_ready),
        .vend_valid(vend_valid_a), .change_valid(change_valid_a), .credit(credit_a),
        .coin_reject(coin_reject_a), .vend_fault(vend_fault_a), .busy(busy_a)
    );

    vend_controller #(.PRICE(255)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .cancel(cancel), .vend_ready(vend_ready), .change_ready(change_ready),
        .vend_valid(vend_valid_b), .change_valid(change_valid_b), .credit(credit_b),
        .coin_reject(coin_reject_b), .vend_fault(vend_fault_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_evt(input int kind, input int c);
        exp_q.push_back(kind * 256 + c);
    endtask

    task automatic note_evt(input int kind, input logic [7:0] c);
        int obs;
        obs = kind * 256 + int'(c);
        if (exp_q.size() == 0) check_val("unexpected_evt", obs, -1);
        else                   check_val("evt", obs, exp_q.pop_front());
    endtask

    // Events on dut_a, sampled on the falling edge ahead of the edge that consumes them.
    always @(negedge clk) begin
        if (coin_reject_a)               note_evt(EV_REJ, credit_a);
        if (vend_fault_a)                note_evt(EV_FAULT, credit_a);
        if (vend_valid_a && vend_ready)  note_evt(EV_VEND, credit_a);
        if (change_valid_a && change_ready) note_evt(EV_CHG, credit_a);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int cr, input int vv, input int cv,
                           input int rj, input int ft, input int bz);
        check_val({tag, "_credit"}, int'(credit_a), cr);
        check_val({tag, "_vend_valid"}, int'(vend_valid_a), vv);
        check_val({tag, "_change_valid"}, int'(change_valid_a), cv);
        check_val({tag, "_coin_reject"}, int'(coin_reject_a), rj);
        check_val({tag, "_vend_fault"}, int'(vend_fault_a), ft);
        check_val({tag, "_busy"}, int'(busy_a), bz);
    endtask

    task automatic coin(input logic [1:0] sel);
        coin_valid = 1'b1;
        coin_sel   = sel;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic drain_change(input int start);
        for (int c = start; c > 0; c -= 5) expect_evt(EV_CHG, c);
        change_ready = 1'b1;
        repeat (start / 5) tick();
        change_ready = 1'b0;
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        coin_valid = 1'b0; coin_sel = 2'd0; cancel = 1'b0;
        vend_ready = 1'b0; change_ready = 1'b0;
        repeat (2) tick();
        check_a("reset_a", 0, 0, 0, 0, 0, 0);
        check_val("reset_b_credit", int'(credit_b), 0);
        check_val("reset_b_busy", int'(busy_b), 0);
        rst_n_a = 1'b1;
        tick();

        // T1: 25 + 10 reaches the price exactly, no change owed.
        coin(2'd2);
        check_a("t1_25", 25, 0, 0, 0, 0, 0);
        coin(2'd1);
        check_a("t1_35", 35, 1, 0, 0, 0, 1);
        expect_evt(EV_VEND, 35);
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        check_a("t1_done", 0, 0, 0, 0, 0, 0);
        tick();
        check_val("t1_no_change", int'(change_valid_a), 0);

        // T2: 50 leaves 15 of change, paid as three units.
        coin(2'd3);
        check_a("t2_vend", 50, 1, 0, 0, 0, 1);
        expect_evt(EV_VEND, 50);
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        check_a("t2_change", 15, 0, 1, 0, 0, 1);
        drain_change(15);
        check_a("t2_idle", 0, 0, 0, 0, 0, 0);

        // T3: cancel refunds; coin with cancel is rejected.
        coin(2'd1);
        check_a("t3_collect", 10, 0, 0, 0, 0, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_a("t3_cancel", 10, 0, 1, 0, 0, 1);
        drain_change(10);
        check_a("t3_idle", 0, 0, 0, 0, 0, 0);
        coin(2'd1);
        expect_evt(EV_REJ, 10);
        cancel = 1'b1;
        coin(2'd0);
        cancel = 1'b0;
        check_a("t3_coin_cancel", 10, 0, 1, 1, 0, 1);
        tick();
        check_val("t3_reject_pulse", int'(coin_reject_a), 0);
        drain_change(10);
        check_a("t3_idle2", 0, 0, 0, 0, 0, 0);

        // T4: coin during VEND rejected, then 16-cycle timeout refunds all 50.
        coin(2'd3);
        expect_evt(EV_REJ, 50);
        coin(2'd0);
        check_a("t4_reject", 50, 1, 0, 1, 0, 1);
        tick();
        check_val("t4_reject_pulse", int'(coin_reject_a), 0);
        repeat (13) tick();
        check_a("t4_pre_timeout", 50, 1, 0, 0, 0, 1);
        expect_evt(EV_FAULT, 50);
        tick();
        check_a("t4_timeout", 50, 0, 1, 0, 1, 1);
        tick();
        check_val("t4_fault_pulse", int'(vend_fault_a), 0);
        drain_change(50);
        check_a("t4_idle", 0, 0, 0, 0, 0, 0);

        // vend_ready on the timeout cycle completes the vend instead.
        coin(2'd3);
        repeat (15) tick();
        check_a("t4b_last", 50, 1, 0, 0, 0, 1);
        expect_evt(EV_VEND, 50);
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        check_a("t4b_vend_wins", 15, 0, 1, 0, 0, 1);
        drain_change(15);
        check_a("t4b_idle", 0, 0, 0, 0, 0, 0);

        // T6: reset in the middle of a refund discards the credit.
        coin(2'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check_a("t6_change", 10, 0, 1, 0, 0, 1);
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        check_a("t6_reset", 0, 0, 0, 0, 0, 0);
        tick();
        check_a("t6_after", 0, 0, 0, 0, 0, 0);

        // T5: PRICE=255 instance, overflow boundary.
        rst_n_a = 1'b0;
        rst_n_b = 1'b1;
        tick();
        repeat (5) coin(2'd3);
        check_val("t5_credit_250", int'(credit_b), 250);
        check_val("t5_no_vend", int'(vend_valid_b), 0);
        coin(2'd3);
        check_val("t5_reject", int'(coin_reject_b), 1);
        check_val("t5_credit_kept", int'(credit_b), 250);
        coin(2'd0);
        check_val("t5_credit_255", int'(credit_b), 255);
        check_val("t5_vend", int'(vend_valid_b), 1);
        check_val("t5_reject_clear", int'(coin_reject_b), 0);
        tick();
        check_val("t5_busy", int'(busy_b), 1);
        check_val("t5_no_change", int'(change_valid_b), 0);

        check_val("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
